// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, payload field position and
// the input arbiter state encoding.
package noc_pkg;

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  localparam int PAYLOAD_MSB = 19;
  localparam int PAYLOAD_LSB = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // SINGLE and TAIL both close a packet and release the wormhole lock.
  function automatic logic ends_packet(logic [1:0] ftype);
    return (ftype == FT_SINGLE) || (ftype == FT_TAIL);
  endfunction

endpackage

// File: rtl/noc_flit_ram.sv
// Simple dual-port flit buffer: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module noc_flit_ram #(
  parameter int DEPTH = 40,
  parameter int AW    = 6,
  parameter int DW    = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register holds its value between pops.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/noc_in_arbiter.sv
// Wormhole round-robin input arbiter feeding one shared circular flit buffer.
// A HEAD flit locks the grant to its port until the packet's TAIL is accepted.
module noc_in_arbiter
  import noc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int FW    = 20,
  parameter int DEPTH = 40,
  parameter int AW    = 6,
  parameter int CW    = 7,
  parameter int SW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*FW-1:0] req_flit,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                rd_req,
  output logic                rd_valid,
  output logic [15:0]         rd_payload,
  output logic [1:0]          rd_type,
  output logic [SW-1:0]       rd_src,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                empty,
  output logic                proto_err
);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [SW-1:0] lock_q, lock_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          perr_q, perr_d;

  logic [N_REQ-1:0] grant_vec;
  logic [SW-1:0]    grant_id;
  logic             accept;
  logic             pop;
  logic [FW-1:0]    acc_flit;
  logic [1:0]       acc_type;
  logic [SW+FW-1:0] ram_rdata;
  logic             unused_rsvd;

  function automatic logic [SW-1:0] rr_after(logic [SW-1:0] id);
    return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Grant depends only on valid, arbiter state, rr pointer and full, so
  // a pop in the same cycle never opens a slot for a full buffer.
  always_comb begin
    int  idx;
    logic found;
    grant_vec = '0;
    grant_id  = '0;
    found     = 1'b0;
    idx       = 0;
    if (!full) begin
      if (state_q == ARB_LOCKED) begin
        if (req_valid[lock_q]) begin
          grant_vec[lock_q] = 1'b1;
          grant_id          = lock_q;
        end
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = int'(rr_q) + k;
          if (idx >= N_REQ) begin
            idx = idx - N_REQ;
          end
          if (!found && req_valid[idx]) begin
            found          = 1'b1;
            grant_vec[idx] = 1'b1;
            grant_id       = SW'(idx);
          end
        end
      end
    end
  end

  assign req_ready = grant_vec;
  assign accept    = |grant_vec;
  assign pop       = rd_req && !empty;
  assign acc_flit  = req_flit[int'(grant_id)*FW +: FW];
  assign acc_type  = acc_flit[1:0];

  // Arbiter FSM: lock on HEAD, release on TAIL/SINGLE, flag type misuse.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    perr_d  = 1'b0;
    if (accept) begin
      case (state_q)
        ARB_IDLE: begin
          if (acc_type == FT_HEAD) begin
            state_d = ARB_LOCKED;
            lock_d  = grant_id;
          end else begin
            rr_d   = rr_after(grant_id);
            perr_d = (acc_type == FT_BODY) || (acc_type == FT_TAIL);
          end
        end
        ARB_LOCKED: begin
          if (ends_packet(acc_type)) begin
            state_d = ARB_IDLE;
            rr_d    = rr_after(lock_q);
          end else if (acc_type == FT_HEAD) begin
            perr_d = 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    rd_valid_d = pop;
    count_d    = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      rr_q       <= '0;
      lock_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      perr_q     <= perr_d;
    end
  end

  noc_flit_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (SW + FW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata ({grant_id, acc_flit}),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign rd_valid    = rd_valid_q;
  assign rd_payload  = ram_rdata[PAYLOAD_MSB:PAYLOAD_LSB];
  assign rd_type     = ram_rdata[1:0];
  assign rd_src      = ram_rdata[SW+FW-1:FW];
  assign unused_rsvd = ^ram_rdata[3:2];
  assign count       = count_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_noc_in_arbiter.sv
// Randomized scoreboard bench for noc_in_arbiter against a queue-based
// model of the wormhole arbitration rules and the FIFO.
module tb_noc_in_arbiter;
  import noc_pkg::*;

  localparam int N = 4, FW = 20, DEPTH = 40, AW = 6, CW = 7, SW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*FW-1:0]   req_flit = '0;
  logic [N-1:0]      req_ready;
  logic              rd_req = 1'b0;
  logic              rd_valid;
  logic [15:0]       rd_payload;
  logic [1:0]        rd_type;
  logic [SW-1:0]     rd_src;
  logic [CW-1:0]     count;
  logic              full, empty, proto_err;

  noc_in_arbiter #(.N_REQ(N), .FW(FW), .DEPTH(DEPTH), .AW(AW), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_payload(rd_payload), .rd_type(rd_type),
    .rd_src(rd_src), .count(count), .full(full), .empty(empty), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            src;
    logic [FW-1:0] flit;
  } entry_t;

  int     checks = 0;
  int     errors = 0;
  entry_t m_fifo[$];
  entry_t exp_q[$];
  bit     m_locked = 0;
  int     m_lock = 0;
  int     m_rr = 0;
  bit     pop_issued = 0;
  bit     exp_perr = 0;
  int     last_grant = -1;
  logic [N-1:0] last_ready = '0;
  logic [FW-1:0] pflit [N];
  bit     pin [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which port should be granted now, from the arbitration rules.
  function automatic int model_grant();
    if (m_fifo.size() == DEPTH) return -1;
    if (m_locked) return req_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_port(input int i, input bit v, input logic [1:0] t, input logic [15:0] pl);
    req_valid[i] = v;
    req_flit[i*FW +: FW] = {pl, 2'b00, t};
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    entry_t e;
    logic [1:0] t;
    #1;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("count", 32'(count), 32'(m_fifo.size()));
    chk("full", 32'(full), 32'(m_fifo.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_fifo.size() == 0));
    last_grant = g;
    last_ready = req_ready;
    @(posedge clk);
    pop_issued = rd_req && (m_fifo.size() > 0);
    if (pop_issued) exp_q.push_back(m_fifo.pop_front());
    exp_perr = 0;
    if (g >= 0) begin
      e.src = g;
      e.flit = req_flit[g*FW +: FW];
      m_fifo.push_back(e);
      t = e.flit[1:0];
      if (!m_locked) begin
        if (t == FT_HEAD) begin
          m_locked = 1;
          m_lock = g;
        end else begin
          m_rr = (g + 1) % N;
          exp_perr = (t == FT_BODY) || (t == FT_TAIL);
        end
      end else if (t == FT_TAIL || t == FT_SINGLE) begin
        m_locked = 0;
        m_rr = (m_lock + 1) % N;
      end else if (t == FT_HEAD) begin
        exp_perr = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rd_req = 1'b0;
    m_fifo.delete();
    exp_q.delete();
    m_locked = 0;
    m_lock = 0;
    m_rr = 0;
    pop_issued = 0;
    exp_perr = 0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic gen(input int i);
    logic [1:0] t;
    int r;
    r = $urandom_range(0, 99);
    if (!pin[i]) t = (r < 45) ? FT_SINGLE : (r < 95) ? FT_HEAD : (r < 97) ? FT_BODY : FT_TAIL;
    else         t = (r < 55) ? FT_BODY : (r < 95) ? FT_TAIL : (r < 97) ? FT_SINGLE : FT_HEAD;
    if (t == FT_HEAD) pin[i] = 1;
    else if (t != FT_BODY) pin[i] = 0;
    pflit[i] = {16'($urandom), 2'($urandom), t};
  endtask

  // Monitor: every popped entry must match the scoreboard's head.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(pop_issued));
      chk("proto_err", 32'(proto_err), 32'(exp_perr));
      if (rd_valid && pop_issued) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_payload", 32'(rd_payload), 32'(e.flit[19:4]));
          chk("rd_type", 32'(rd_type), 32'(e.flit[1:0]));
          chk("rd_src", 32'(rd_src), 32'(e.src));
        end
      end
    end
  end

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    @(negedge clk);
    do_reset();

    // single flit from port 2, then pop it
    set_port(2, 1, FT_SINGLE, 16'hABCD);
    step();
    chk("t1_ready", 32'(last_ready), 32'h4);
    req_valid = '0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("t1_payload", 32'(rd_payload), 32'hABCD);
    chk("t1_src", 32'(rd_src), 32'd2);

    // round-robin over four always-valid ports
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 1, FT_SINGLE, 16'(16'h100 + i));
    rd_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t2_grant", 32'(last_ready), 32'(1 << exp_order[c]));
    end

    // wormhole lock on port 1 blocks port 0
    req_valid = '0;
    set_port(0, 1, FT_SINGLE, 16'h0F00);
    set_port(1, 1, FT_HEAD, 16'h1001);
    step();
    chk("t3_p0_blocked_head", 32'(last_ready[0]), 32'd0);
    set_port(1, 1, FT_BODY, 16'h1002);
    step();
    chk("t3_p0_blocked_body", 32'(last_ready[0]), 32'd0);
    set_port(1, 1, FT_TAIL, 16'h1003);
    step();
    chk("t3_p0_blocked_tail", 32'(last_ready[0]), 32'd0);
    req_valid[1] = 1'b0;
    step();
    chk("t3_p0_granted", 32'(last_ready), 32'h1);

    // fill to full, push+pop at 39, drain with wrap
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      set_port(0, 1, FT_SINGLE, 16'(16'h2000 + c));
      step();
    end
    step();
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ready_full", 32'(last_ready), 32'd0);
    req_valid = '0;
    rd_req = 1'b1;
    step();
    set_port(0, 1, FT_SINGLE, 16'h2FFF);
    step();
    chk("t4_count39", 32'(count), 32'd39);
    req_valid = '0;
    for (int c = 0; c < DEPTH; c++) step();
    chk("t4_empty", 32'(empty), 32'd1);

    // BODY while idle, then pop on empty
    do_reset();
    set_port(3, 1, FT_BODY, 16'h3333);
    step();
    chk("t5_ready", 32'(last_ready), 32'h8);
    req_valid = '0;
    rd_req = 1'b1;
    step();
    step();
    step();
    rd_req = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_no_valid", 32'(rd_valid), 32'd0);

    // reset in the middle of a locked packet
    do_reset();
    set_port(1, 1, FT_HEAD, 16'h4000);
    step();
    for (int c = 0; c < 4; c++) begin
      set_port(1, 1, FT_BODY, 16'(16'h4001 + c));
      step();
    end
    chk("t6_count5", 32'(count), 32'd5);
    do_reset();
    set_port(0, 1, FT_SINGLE, 16'h5000);
    set_port(1, 1, FT_BODY, 16'h5001);
    step();
    chk("t6_fresh_grant", 32'(last_ready), 32'h1);

    // randomized traffic with alternating fill/drain read pressure
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      pin[i] = 0;
      gen(i);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 70);
        req_flit[i*FW +: FW] = pflit[i];
      end
      rd_req = ($urandom_range(0, 99) < (((c / 200) % 2 == 1) ? 85 : 25));
      step();
      if (last_grant >= 0) gen(last_grant);
    end
    req_valid = '0;
    rd_req = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
